// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the core and its memory-side blocks.
// Holds the instruction codes that touch data memory, the status codes and the responder state encoding.
package y86_pkg;

    localparam int WORD_W = 64;

    // Instruction codes that generate data-memory traffic
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] ADR = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

    // Maps a memory error flag onto the core's status code.
    function automatic logic [2:0] mem_stat(input logic err);
        return err ? ADR : AOK;
    endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-addressed backing store: 8-byte little-endian synchronous write, 8-byte combinational read.
// Lane addresses wrap within the array; callers discard data for out-of-range accesses.
module y86_byte_ram
    import y86_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = WORD_W / 8;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lane_addr [NBYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign lane_addr[gi]     = addr + ADDR_W'(gi);
            assign rdata[8*gi +: 8]  = mem[lane_addr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem[lane_addr[i]] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/y86_dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store, waits LATENCY cycles,
// performs the access on entry to RESP and holds the response until the requester takes it.
module y86_dmem_responder
    import y86_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    rsp_state_e        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              write_reg;
    logic [WORD_W-1:0] addr_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic [WORD_W-1:0] rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              respond;
    logic              access;
    logic              acc_write;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_err;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    assign accept  = req_valid && req_ready;
    assign respond = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        access     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    access     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (respond) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A single-cycle build accesses straight from the request bus; otherwise from the latched copy.
    assign acc_write = (state_reg == IDLE) ? req_write : write_reg;
    assign acc_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

    assign acc_err = (acc_addr[WORD_W-1:ADDR_W] != '0) ||
                     (acc_addr[ADDR_W-1:0] > ADDR_W'(DEPTH - 8));

    // Gating with rst keeps a store from committing while the FSM is held in reset.
    assign ram_we = access && acc_write && !acc_err && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (access) begin
                err_reg   <= acc_err;
                rdata_reg <= (acc_err || acc_write) ? '0 : ram_rdata;
            end else if (respond) begin
                err_reg   <= 1'b0;
                rdata_reg <= '0;
            end
        end
    end

    y86_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[ADDR_W-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Randomized bench for y86_dmem_responder against a byte-array reference memory.
// A second instance built with LATENCY = 1 covers the back-to-back single-cycle case.
module tb_y86_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        req1_valid, req1_ready, req1_write;
    logic [63:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [63:0] rsp1_rdata;

    logic [7:0]  mdl  [1024];
    logic [7:0]  mdl1 [1024];

    int n_checks = 0;
    int n_errors = 0;

    y86_dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    y86_dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req1_valid), .req_ready(req1_ready), .req_write(req1_write),
        .req_addr(req1_addr), .req_wdata(req1_wdata),
        .rsp_valid(rsp1_valid), .rsp_ready(rsp1_ready),
        .rsp_rdata(rsp1_rdata), .rsp_err(rsp1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: quadword at addr..addr+7, error past DEPTH-8 or on any high address bit.
    task automatic model_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                                output logic [63:0] exp_d, output logic exp_e);
        logic [9:0] ai;
        exp_e = (addr > 64'd1016);
        exp_d = '0;
        if (!exp_e) begin
            for (int i = 0; i < 8; i++) begin
                ai = addr[9:0] + 10'(i);
                if (wr) mdl[ai] = wd[8*i +: 8];
                else    exp_d[8*i +: 8] = mdl[ai];
            end
        end
    endtask

    // One full transaction on the LATENCY = 2 instance, with optional response backpressure
    // and optional req_valid held (with a scrambled bus) while the request is outstanding.
    task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                       input int bp, input bit hold,
                       output logic [63:0] got_d, output logic got_e);
        logic [63:0] exp_d;
        logic        exp_e;
        int          guard;
        int          lat;
        model_access(wr, addr, wd, exp_d, exp_e);
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        rsp_ready = (bp == 0);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (hold) begin
                req_addr = {$urandom, $urandom}; req_write = 1'($urandom);
            end
            @(posedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        got_d = rsp_rdata;
        got_e = rsp_err;
        check("rdata", got_d, exp_d);
        check("err", 64'(got_e), 64'(exp_e));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (hold) req_addr = {$urandom, $urandom};
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rdata", rsp_rdata, got_d);
            check("bp_err", 64'(rsp_err), 64'(got_e));
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("post_req_ready", 64'(req_ready), 64'd1);
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] d, v, a;
        logic        e;
        int          sel, guard;
        logic        l1_w [10];
        logic [63:0] l1_a [10];
        logic [63:0] l1_d [10];
        logic [63:0] e1_d;
        logic        e1_e;
        logic [9:0]  ai;
        int          idx, pend, acc_prev, acc_cyc;

        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rdata", rsp_rdata, 64'd0);
        check("reset_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill the whole store so every later load has a known reference value.
        for (int k = 0; k < 128; k++) txn(1'b1, 64'(k * 8), {$urandom, $urandom}, 0, 1'b0, d, e);

        // Store then aligned and unaligned reload.
        txn(1'b1, 64'h100, 64'h0123456789ABCDEF, 0, 1'b0, d, e);
        check("t1_store_rdata", d, 64'd0);
        check("t1_store_err", 64'(e), 64'd0);
        txn(1'b0, 64'h100, 64'd0, 0, 1'b0, d, e);
        check("t1_load100", d, 64'h0123456789ABCDEF);
        txn(1'b0, 64'h101, 64'd0, 0, 1'b0, d, e);
        check("t1_load101_low", {8'h00, d[55:0]}, 64'h0001_2345_6789_ABCD);

        // Backpressure on a load response.
        txn(1'b0, 64'h100, 64'd0, 5, 1'b0, d, e);

        // Range boundary.
        txn(1'b0, 64'h3F8, 64'd0, 0, 1'b0, v, e);
        check("t3_3f8_err", 64'(e), 64'd0);
        txn(1'b0, 64'h3F9, 64'd0, 0, 1'b0, d, e);
        check("t3_3f9_err", 64'(e), 64'd1);
        check("t3_3f9_rdata", d, 64'd0);
        txn(1'b1, 64'h400, 64'hDEADBEEFCAFEF00D, 0, 1'b0, d, e);
        check("t3_400_err", 64'(e), 64'd1);
        txn(1'b0, 64'h3F8, 64'd0, 0, 1'b0, d, e);
        check("t3_3f8_unchanged", d, v);

        // Reset while a store waits: outputs clear at once and the store never lands.
        @(negedge clk);
        req_write = 1'b1; req_addr = 64'h200; req_wdata = 64'hFFFF; req_valid = 1'b1; rsp_ready = 1'b1;
        check("t5_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_req_ready", 64'(req_ready), 64'd1);
        check("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_rst_rdata", rsp_rdata, 64'd0);
        check("t5_rst_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 64'h200, 64'd0, 0, 1'b0, d, e);

        // Reset while a load response is held: registered outputs clear asynchronously.
        @(negedge clk);
        req_write = 1'b0; req_addr = 64'h100; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("rr_pre_rdata", rsp_rdata, 64'h0123456789ABCDEF);
        #1 rst = 1'b1;
        #1;
        check("rr_rst_rdata", rsp_rdata, 64'd0);
        check("rr_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rr_rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;

        // req_valid held with a changing bus while outstanding; no extra responses afterwards.
        txn(1'b1, 64'h180, 64'h1122334455667788, 1, 1'b1, d, e);
        txn(1'b0, 64'h180, 64'd0, 2, 1'b1, d, e);
        check("t6_load", d, 64'h1122334455667788);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_extra", 64'(rsp_valid), 64'd0);
        end

        // Randomized traffic.
        for (int k = 0; k < 80; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = {32'($urandom), 32'($urandom)} | 64'h1_0000_0000;
            else if (sel == 1) a = 64'($urandom_range(1017, 1023));
            else               a = 64'($urandom_range(0, 1016));
            txn(1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0), d, e);
        end

        // LATENCY = 1 instance: back-to-back with req_valid held and rsp_ready tied high.
        l1_w = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        l1_a = '{64'h40, 64'h48, 64'h50, 64'h58, 64'h40, 64'h44, 64'h58, 64'h3F9, 64'h3FC, 64'h50};
        for (int i = 0; i < 10; i++) l1_d[i] = {$urandom, $urandom};
        idx = 0; pend = 0; acc_prev = -1; acc_cyc = 0; e1_d = '0; e1_e = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (rsp1_valid) begin
                check("l1_rsp_lat", 64'(cyc - acc_cyc), 64'd1);
                check("l1_rdata", rsp1_rdata, e1_d);
                check("l1_err", 64'(rsp1_err), 64'(e1_e));
                pend--;
                check("l1_one_rsp", 64'(pend), 64'd0);
            end
            if (req1_ready && idx < 10) begin
                req1_valid = 1'b1; req1_write = l1_w[idx];
                req1_addr = l1_a[idx]; req1_wdata = l1_d[idx];
                e1_e = (l1_a[idx] > 64'd1016);
                e1_d = '0;
                if (!e1_e) begin
                    for (int i = 0; i < 8; i++) begin
                        ai = l1_a[idx][9:0] + 10'(i);
                        if (l1_w[idx]) mdl1[ai] = l1_d[idx][8*i +: 8];
                        else           e1_d[8*i +: 8] = mdl1[ai];
                    end
                end
                if (acc_prev >= 0) check("l1_spacing", 64'(cyc - acc_prev), 64'd2);
                acc_prev = cyc; acc_cyc = cyc;
                pend++; idx++;
            end else if (req1_ready) begin
                req1_valid = 1'b0;
            end
        end
        check("l1_all_issued", 64'(idx), 64'd10);
        check("l1_all_answered", 64'(pend), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
